// File: rtl/seg7_count_display.sv
// Two-digit multiplexed common-anode seven-segment driver for a 4-bit counter value.
// DIN is synchronized and filtered. The ones and tens digits are then scanned with dark gaps between them.
module seg7_count_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500,
    parameter int unsigned LZB       = 1
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic [3:0] DIN,
    output logic [6:0] SEG,
    output logic [1:0] DIG,
    output logic       UPD
);

    localparam int unsigned MAX_LEN = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [6:0]       SEG_OFF    = 7'h7F;
    localparam logic [1:0]       DIG_OFF    = 2'b11;
    localparam logic [1:0]       DIG_ONES   = 2'b10;
    localparam logic [1:0]       DIG_TENS   = 2'b01;

    typedef enum logic [1:0] {
        S_GAP0,
        S_ONES,
        S_GAP1,
        S_TENS
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sync1_q, sync2_q, prev_q;
    logic [3:0]       disp_val_q, disp_val_d;
    logic [3:0]       digit_q, digit_d;
    logic [6:0]       seg_d;
    logic [1:0]       dig_d;
    logic             upd_d;
    logic             tens_c;
    logic [3:0]       ones_c;

    // Active-low segment pattern {g,f,e,d,c,b,a} for a decimal digit.
    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] c;
        unique case (v)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = 7'b1111111;
        endcase
        return c;
    endfunction

    // Next-state, filter update and registered-output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        disp_val_d = disp_val_q;
        digit_d    = digit_q;
        seg_d      = SEG;
        dig_d      = DIG;
        upd_d      = 1'b0;
        tens_c     = 1'b0;
        ones_c     = 4'd0;

        if ((sync2_q == prev_q) && (sync2_q != disp_val_q)) begin
            disp_val_d = sync2_q;
            upd_d      = 1'b1;
        end

        unique case (state_q)
            S_GAP0: if (cnt_q == BLANK_LAST) state_d = S_ONES;
            S_ONES: if (cnt_q == SCAN_LAST)  state_d = S_GAP1;
            S_GAP1: if (cnt_q == BLANK_LAST) state_d = S_TENS;
            S_TENS: if (cnt_q == SCAN_LAST)  state_d = S_GAP0;
        endcase

        // The digit latch samples the pre-edge disp_val on digit entry.
        if (state_d != state_q) begin
            cnt_d = '0;
            if ((state_d == S_ONES) || (state_d == S_TENS)) begin
                digit_d = disp_val_q;
            end
            tens_c = (digit_d >= 4'd10);
            ones_c = tens_c ? (digit_d - 4'd10) : digit_d;
            unique case (state_d)
                S_ONES: begin
                    seg_d = seg_code(ones_c);
                    dig_d = DIG_ONES;
                end
                S_TENS: begin
                    if (!tens_c && (LZB != 0)) begin
                        seg_d = SEG_OFF;
                        dig_d = DIG_OFF;
                    end else begin
                        seg_d = seg_code({3'b000, tens_c});
                        dig_d = DIG_TENS;
                    end
                end
                default: begin
                    seg_d = SEG_OFF;
                    dig_d = DIG_OFF;
                end
            endcase
        end
    end

    // State, scan counter, input pipeline and output registers.
    always_ff @(posedge CLK_50M) begin
        if (!RST) begin
            state_q    <= S_GAP0;
            cnt_q      <= '0;
            sync1_q    <= 4'd0;
            sync2_q    <= 4'd0;
            prev_q     <= 4'd0;
            disp_val_q <= 4'd0;
            digit_q    <= 4'd0;
            SEG        <= SEG_OFF;
            DIG        <= DIG_OFF;
            UPD        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync1_q    <= DIN;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            disp_val_q <= disp_val_d;
            digit_q    <= digit_d;
            SEG        <= seg_d;
            DIG        <= dig_d;
            UPD        <= upd_d;
        end
    end

endmodule

// File: doc/seg7_count_display.md
Name: seg7_count_display

Overview:
- Downstream consumer of the 4-bit 1 Hz counter value (0–15).
- Shows the value as two decimal digits (00–15) on a two-digit, common-anode, multiplexed seven-segment display. All logic runs in the 50 MHz domain.
- Input handling: two-flop synchronizer plus stability filter, because the counter value changes on a divided clock.
- Output timing: segment and digit strobes are scanned by a state machine with blanking gaps, to suppress ghosting.

Parameters:
- SCAN_DIV, 50000: CLK_50M cycles each digit is lit (1 ms at 50 MHz).
- BLANK_CYC, 500: CLK_50M cycles both digits are dark between digits.
- LZB, 1: 1 = blank the tens digit when it is 0; 0 = show a leading '0'.

Ports:
- CLK_50M  in  1  system clock, 50 MHz.
- RST  in  1  synchronous, active-low reset, sampled on the CLK_50M rising edge.
- DIN  in  4  counter value, asynchronous to the scan timing; treated as unsigned 0–15.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- DIG  out  2  digit enables, active-low; DIG[0] = ones, DIG[1] = tens.
- UPD  out  1  one-cycle pulse when the displayed value changes.

Behaviour:
- Clock/reset: one clock (CLK_50M). Reset is synchronous, active-low (RST); polarity and synchronicity are fixed.
- Reset (RST=0 at a rising edge):
  - sync1, sync2, prev and disp_val all go to 0.
  - Scan counter goes to 0; state goes to S_GAP0.
  - Outputs: SEG=7'h7F, DIG=2'b11, UPD=0.
  - Reset wins over every other event, including mid-digit.
- Input path:
  - DIN → sync1 → sync2; prev <= sync2 every cycle.
  - When sync2==prev and sync2!=disp_val: disp_val <= sync2 and UPD=1 for exactly that cycle.
  - A DIN change held ≥2 cycles reaches disp_val 3 edges after it is sampled.
  - A single-cycle DIN glitch never updates disp_val.
- Decode (combinational from the digit latch):
  - tens = (v>=10); ones = v-10 if v>=10, else v. Use 4-bit arithmetic; no value exceeds 15.
  - Active-low codes:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Scan FSM (one down/up counter, reloaded on every state change):
  - S_GAP0 lasts BLANK_CYC cycles, then → S_ONES.
  - S_ONES lasts SCAN_DIV cycles, then → S_GAP1.
  - S_GAP1 lasts BLANK_CYC cycles, then → S_TENS.
  - S_TENS lasts SCAN_DIV cycles, then → S_GAP0.
  - Full frame = 2·SCAN_DIV + 2·BLANK_CYC cycles (101000 at defaults, ≈495 Hz refresh).
  - The counter wraps to 0 on the edge that changes state; no cycle is lost or duplicated.
- Outputs are registered and change on the same edge as the state transition:
  - Gap states: DIG=11, SEG=7F.
  - S_ONES: DIG=10, SEG=code(ones).
  - S_TENS: DIG=01, SEG=code(1). If tens==0 and LZB=1: DIG=11, SEG=7F; the state still lasts SCAN_DIV cycles.
- Digit value latch: disp_val is latched into the digit register on the entry edge of S_ONES/S_TENS.
  - A disp_val change mid-digit does not alter SEG until the next digit entry.
  - Both digits within one frame may therefore show values from different samples; this is accepted.
- Simultaneous events: a disp_val update on a state-entry edge uses the old disp_val for that entry, because the latch samples the pre-edge register.

Test Plan:
All scenarios use SCAN_DIV=4, BLANK_CYC=2, LZB=1.
1. Reset: RST=0 for 3 cycles, with DIN=9 → SEG=7F, DIG=11, UPD=0 throughout. After release, state changes on edges 2 (S_ONES), 6 (S_GAP1), 8 (S_TENS) and 12 (S_GAP0); S_ONES shows DIG=10, SEG=1000000.
2. DIN=7 held → UPD high exactly one cycle, 3 edges after DIN is sampled. Next S_ONES gives SEG=1111000, DIG=10; S_TENS gives DIG=11, SEG=7F.
3. DIN=12 held → S_ONES gives SEG=0100100, DIG=10; S_TENS gives SEG=1111001, DIG=01. Frame period is 12 cycles.
4. Glitch: DIN=5 stable, then 6 for one cycle, then 5 → no UPD pulse; display stays 5 (SEG=0010010).
5. Wrap: DIN 15 → 0 → UPD pulses twice. The display goes from tens=1/ones=0010010 to ones=1000000 with tens blank.
6. Reset mid-S_TENS while showing 13 → next edge SEG=7F, DIG=11. After release the display shows 0 (ones only), with the first S_ONES 2 cycles after release.
